// File: rtl/flash_controller.sv
// flash_controller: self-starting bring-up sequencer for one ONFI NV-DDR NAND package.
// After reset it waits out power-up, issues RESET (0xFF), waits tRST, issues READ ID (0x90)
// with address 0x00, then opens a fixed data-output window and captures the first ID byte
// on the first DQS rise (sysClk rising edge -> DEBUG, following falling edge -> DEBUG90).
//
// Ports:
//   CLK_sysClkP   in    system clock, the only clock used by the logic
//   CLK_sysClkN   in    complement leg, pin only
//   RST_N_sysRstn in    asynchronous active-low reset
//   DQ[7:0]       inout NAND data bus, driven only during command/address beats
//   DQS           inout NAND strobe, never driven, sampled only
//   NAND_CLK      out   NAND clock, sysClk/2
//   CLE, ALE      out   command / address latch enables
//   WRN           out   W/R# (1 = host writes, 0 = NAND drives)
//   WPN           out   write protect, active low
//   CEN[1:0]      out   chip enables, active low; CEN[1] held high
//   DEBUG[7:0]    out   ID byte captured on sysClk rising edge
//   DEBUG90[7:0]  out   ID byte captured on the following sysClk falling edge
module flash_controller #(
  parameter int unsigned POWERUP_CYC = 5000,
  parameter int unsigned TRST_CYC    = 50000,
  parameter int unsigned TWHR_CYC    = 4,
  parameter int unsigned READ_CYC    = 8
) (
  input  logic       CLK_sysClkP,
  input  logic       CLK_sysClkN,
  input  logic       RST_N_sysRstn,
  inout  wire  [7:0] DQ,
  inout  wire        DQS,
  output logic       NAND_CLK,
  output logic       CLE,
  output logic       ALE,
  output logic       WRN,
  output logic       WPN,
  output logic [1:0] CEN,
  output logic [7:0] DEBUG,
  output logic [7:0] DEBUG90
);

  localparam int unsigned MaxCyc = (POWERUP_CYC > TRST_CYC) ? POWERUP_CYC : TRST_CYC;
  localparam int unsigned CntW   = ($clog2(MaxCyc) < 17) ? 17 : $clog2(MaxCyc);

  typedef enum logic [2:0] {
    StPowerup, StCmdRst, StWaitRst, StCmdId, StAddrId, StWaitWhr, StRead, StDone
  } state_e;

  function automatic logic [CntW-1:0] last_cnt(input int unsigned n);
    return CntW'(n - 1);
  endfunction

  logic unused_clk_n;
  assign unused_clk_n = CLK_sysClkN;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            nand_clk_q, nand_clk_d;
  logic            cle_q, cle_d, ale_q, ale_d, wrn_q, wrn_d, wpn_q, wpn_d, cen0_q, cen0_d;
  logic            dq_oe_q, dq_oe_d;
  logic [7:0]      dq_out_q, dq_out_d;
  logic            dqs_q, dqs_prev_q;
  logic            cap_q, cap_d, cap90_q, cap90_d;
  logic [7:0]      debug_q, debug_d, debug90_q, debug90_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nand_clk_d = ~nand_clk_q;
    cle_d      = cle_q;
    ale_d      = ale_q;
    wrn_d      = wrn_q;
    wpn_d      = wpn_q;
    cen0_d     = cen0_q;
    dq_oe_d    = dq_oe_q;
    dq_out_d   = dq_out_q;
    // Pins advance only when NAND_CLK falls, so they are stable around its rising edge.
    if (nand_clk_q) begin
      case (state_q)
        StPowerup: begin
          if (cnt_q == last_cnt(POWERUP_CYC)) begin
            cnt_d    = '0;
            state_d  = StCmdRst;
            wpn_d    = 1'b1;
            cen0_d   = 1'b0;
            cle_d    = 1'b1;
            ale_d    = 1'b0;
            wrn_d    = 1'b1;
            dq_oe_d  = 1'b1;
            dq_out_d = 8'hff;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCmdRst: begin
          state_d = StWaitRst;
          cle_d   = 1'b0;
          dq_oe_d = 1'b0;
        end
        StWaitRst: begin
          if (cnt_q == last_cnt(TRST_CYC)) begin
            cnt_d    = '0;
            state_d  = StCmdId;
            cle_d    = 1'b1;
            dq_oe_d  = 1'b1;
            dq_out_d = 8'h90;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCmdId: begin
          state_d  = StAddrId;
          cle_d    = 1'b0;
          ale_d    = 1'b1;
          dq_out_d = 8'h00;
        end
        StAddrId: begin
          state_d = StWaitWhr;
          ale_d   = 1'b0;
          dq_oe_d = 1'b0;
        end
        StWaitWhr: begin
          if (cnt_q == last_cnt(TWHR_CYC)) begin
            cnt_d   = '0;
            state_d = StRead;
            wrn_d   = 1'b0;
            cle_d   = 1'b1;
            ale_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRead: begin
          if (cnt_q == last_cnt(READ_CYC)) begin
            cnt_d   = '0;
            state_d = StDone;
            cle_d   = 1'b0;
            ale_d   = 1'b0;
            wrn_d   = 1'b1;
            cen0_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StPowerup;
      endcase
    end
  end

  // First registered DQS rise inside the read window latches the ID byte exactly once.
  always_comb begin
    cap_d   = cap_q;
    debug_d = debug_q;
    if ((state_q == StRead) && !cap_q && dqs_q && !dqs_prev_q) begin
      cap_d   = 1'b1;
      debug_d = DQ;
    end
  end

  always_comb begin
    cap90_d   = cap90_q;
    debug90_d = debug90_q;
    if (cap_q && !cap90_q) begin
      cap90_d   = 1'b1;
      debug90_d = DQ;
    end
  end

  always_ff @(posedge CLK_sysClkP or negedge RST_N_sysRstn) begin
    if (!RST_N_sysRstn) begin
      state_q    <= StPowerup;
      cnt_q      <= '0;
      nand_clk_q <= 1'b0;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      wrn_q      <= 1'b1;
      wpn_q      <= 1'b0;
      cen0_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= 8'h00;
      dqs_q      <= 1'b0;
      dqs_prev_q <= 1'b0;
      cap_q      <= 1'b0;
      debug_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nand_clk_q <= nand_clk_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      wrn_q      <= wrn_d;
      wpn_q      <= wpn_d;
      cen0_q     <= cen0_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
      dqs_q      <= DQS;
      dqs_prev_q <= dqs_q;
      cap_q      <= cap_d;
      debug_q    <= debug_d;
    end
  end

  always_ff @(negedge CLK_sysClkP or negedge RST_N_sysRstn) begin
    if (!RST_N_sysRstn) begin
      cap90_q   <= 1'b0;
      debug90_q <= 8'h00;
    end else begin
      cap90_q   <= cap90_d;
      debug90_q <= debug90_d;
    end
  end

  assign DQ       = dq_oe_q ? dq_out_q : 8'hzz;
  assign DQS      = 1'bz;
  assign NAND_CLK = nand_clk_q;
  assign CLE      = cle_q;
  assign ALE      = ale_q;
  assign WRN      = wrn_q;
  assign WPN      = wpn_q;
  assign CEN      = {1'b1, cen0_q};
  assign DEBUG    = debug_q;
  assign DEBUG90  = debug90_q;

endmodule

// File: tb/tb_flash_controller.sv
// Directed bench for flash_controller with short timers (POWERUP=4, TRST=10, TWHR=4, READ=8).
// A small in-bench NAND responder drives ID byte 0x2C with one DQS rise during the read window.
`timescale 1ns/1ps
module tb_flash_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire  [7:0] dq_bus;
  wire        dqs_bus;
  logic       nand_clk, cle, ale, wrn, wpn;
  logic [1:0] cen;
  logic [7:0] debug, debug90;

  logic       model_en = 1'b0;
  logic       dqs_hold_low = 1'b0;
  logic       dq_oe, dqs_oe, dqs_val;
  logic [7:0] dq_val;

  int total = 0;
  int bad = 0;

  assign dq_bus  = dq_oe ? dq_val : 8'hzz;
  assign dqs_bus = dqs_oe ? dqs_val : (dqs_hold_low ? 1'b0 : 1'bz);

  always #5 clk = ~clk;

  flash_controller #(
    .POWERUP_CYC(4),
    .TRST_CYC   (10),
    .TWHR_CYC   (4),
    .READ_CYC   (8)
  ) dut (
    .CLK_sysClkP  (clk),
    .CLK_sysClkN  (~clk),
    .RST_N_sysRstn(rst_n),
    .DQ           (dq_bus),
    .DQS          (dqs_bus),
    .NAND_CLK     (nand_clk),
    .CLE          (cle),
    .ALE          (ale),
    .WRN          (wrn),
    .WPN          (wpn),
    .CEN          (cen),
    .DEBUG        (debug),
    .DEBUG90      (debug90)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pin monitor: beat k is the NAND_CLK-high phase of the k-th NAND_CLK cycle after release.
  int beat_q, ff_beat, ff_cnt, id_beat, addr_beat, addr_cnt, read_beat;
  logic ff_seen, ff_wpn, id_seen, id_wrn, read_seen, done_seen;
  logic pu_bad, cen_break, dq_in_read;

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_q <= 0; ff_beat <= -1; ff_cnt <= 0; id_beat <= -1; addr_beat <= -1;
      addr_cnt <= 0; read_beat <= -1; ff_seen <= 1'b0; ff_wpn <= 1'b0; id_seen <= 1'b0;
      id_wrn <= 1'b0; read_seen <= 1'b0; done_seen <= 1'b0; pu_bad <= 1'b0;
      cen_break <= 1'b0; dq_in_read <= 1'b0;
    end else begin
      if (nand_clk) begin
        beat_q <= beat_q + 1;
        if (cle && !ale && wrn && dq_bus === 8'hff) begin
          ff_cnt <= ff_cnt + 1;
          if (!ff_seen) begin
            ff_beat <= beat_q;
            ff_wpn  <= wpn;
          end
          ff_seen <= 1'b1;
        end
        if (cle && !ale && dq_bus === 8'h90 && !id_seen) begin
          id_seen <= 1'b1;
          id_beat <= beat_q;
          id_wrn  <= wrn;
        end
        if (ale && !cle && wrn && dq_bus === 8'h00) begin
          addr_cnt <= addr_cnt + 1;
          if (addr_beat < 0) addr_beat <= beat_q;
        end
        if (!wrn && cle && ale && !read_seen) begin
          read_seen <= 1'b1;
          read_beat <= beat_q;
        end
      end
      if (!ff_seen && !(cle && dq_bus === 8'hff) && (cen !== 2'b11 || dq_bus !== 8'hzz))
        pu_bad <= 1'b1;
      if (ff_seen && !(read_seen && wrn) && cen[0]) cen_break <= 1'b1;
      if (!wrn && dq_bus !== 8'hzz) dq_in_read <= 1'b1;
      if (read_seen && wrn && cen === 2'b11) done_seen <= 1'b1;
    end
  end

  // NAND responder: once the read window opens, present 0x2C and raise DQS once.
  initial begin
    dq_oe = 1'b0; dqs_oe = 1'b0; dq_val = 8'h00; dqs_val = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && rst_n && wrn == 1'b0 && cle && ale) begin
        dq_val = 8'h2c; dq_oe = 1'b1; dqs_val = 1'b0; dqs_oe = 1'b1;
        repeat (2) @(negedge clk);
        dqs_val = 1'b1;
        repeat (6) @(negedge clk);
        dq_oe = 1'b0; dqs_oe = 1'b0; dqs_val = 1'b0;
        while (rst_n && wrn == 1'b0) @(negedge clk);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clk);
    check("done_reached", done_seen, 1'b1);
  endtask

  initial begin
    longint t0, t1;
    logic   prev;
    int     rises;

    // Run A: reset values, timing of command beats, ID capture with responder.
    model_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_nand_clk", nand_clk, 1'b0);
    check("rst_cen", cen, 2'b11);
    check("rst_cle", cle, 1'b0);
    check("rst_ale", ale, 1'b0);
    check("rst_wrn", wrn, 1'b1);
    check("rst_wpn", wpn, 1'b0);
    check("rst_debug", debug, 8'h00);
    check("rst_debug90", debug90, 8'h00);
    check("rst_dq_z", dq_bus === 8'hzz, 1'b1);
    check("rst_dqs_z", dqs_bus === 1'bz, 1'b1);
    release_reset();
    @(negedge clk);
    check("pu_cen", cen, 2'b11);
    check("pu_dqs_z", dqs_bus === 1'bz, 1'b1);
    t0 = 0; t1 = 0; rises = 0; prev = nand_clk;
    for (int i = 0; i < 10 && rises < 2; i++) begin
      @(negedge clk);
      if (nand_clk && !prev) begin
        if (rises == 0) t0 = $time;
        else t1 = $time;
        rises++;
      end
      prev = nand_clk;
    end
    check("nand_clk_period", 32'(t1 - t0), 32'd20);
    wait_done();
    check("ff_beat", ff_beat, 4);
    check("ff_once", ff_cnt, 1);
    check("wpn_at_ff", ff_wpn, 1'b1);
    check("id_beat", id_beat, 15);
    check("id_wrn", id_wrn, 1'b1);
    check("addr_beat", addr_beat, 16);
    check("addr_once", addr_cnt, 1);
    check("read_beat", read_beat, 21);
    check("pu_quiet", pu_bad, 1'b0);
    check("cen0_low_run", cen_break, 1'b0);
    check("debug_id", debug, 8'h2c);
    check("debug90_id", debug90, 8'h2c);
    check("done_cen", cen, 2'b11);
    check("done_dq_z", dq_bus === 8'hzz, 1'b1);

    // Run C: reset in the middle of WAIT_RST, then a full restart.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
    for (int i = 0; i < 200 && !(ff_seen && beat_q >= 8); i++) @(negedge clk);
    check("in_wait_rst", cen[0], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_nand_clk", nand_clk, 1'b0);
    check("mid_rst_cen", cen, 2'b11);
    check("mid_rst_cle", cle, 1'b0);
    check("mid_rst_wrn", wrn, 1'b1);
    check("mid_rst_wpn", wpn, 1'b0);
    check("mid_rst_dq_z", dq_bus === 8'hzz, 1'b1);
    repeat (3) @(negedge clk);
    release_reset();
    for (int i = 0; i < 200 && !ff_seen; i++) @(negedge clk);
    check("restart_ff_beat", ff_beat, 4);

    // Run B: DQS held low, no responder.
    model_en = 1'b0;
    dqs_hold_low = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
    wait_done();
    check("nodqs_debug", debug, 8'h00);
    check("nodqs_debug90", debug90, 8'h00);
    check("nodqs_dq_undriven", dq_in_read, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
